// File: rtl/fan_pkg.sv
// fan_pkg: shared state encoding, default duty constants and level-to-LED helper
package fan_pkg;
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} fan_state_t;
    localparam int DEF_DUTY_MAX  = 100;
    localparam int DEF_DUTY_STEP = 10;
    function automatic logic [14:0] lvl_onehot(input logic [3:0] lvl);
        return (lvl == 4'd0) ? 15'd0 : 15'd1 << (lvl - 4'd1);
    endfunction
endpackage

// File: rtl/fan_pwm_gen.sv
// fan_pwm_gen: prescaled free-running PWM counter with registered duty compare
module fan_pwm_gen
    import fan_pkg::*;
#(
    parameter int DUTY_MAX = DEF_DUTY_MAX,
    parameter int PWM_DIV  = 1
) (
    input  logic                              clk,
    input  logic                              reset_p,
    input  logic [$clog2(DUTY_MAX+1)-1:0]     duty,
    output logic                              pwm
);
    localparam int DUTY_W = $clog2(DUTY_MAX + 1);
    localparam int DIV_W  = $clog2(PWM_DIV + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PWM_DIV - 1);
    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(DUTY_MAX - 1);
    logic [DIV_W-1:0]  div_cnt;
    logic [DUTY_W-1:0] cnt;
    logic              step;
    assign step = div_cnt == DIV_LAST;
    // prescaler advances the period counter; compare is registered so duty edits land on the next count
    always_ff @(posedge clk) begin
        if (reset_p) begin
            div_cnt <= '0;
            cnt     <= '0;
            pwm     <= 1'b0;
        end else begin
            div_cnt <= step ? '0 : div_cnt + 1'b1;
            cnt     <= !step ? cnt : (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            pwm     <= cnt < duty;
        end
    end
endmodule

// File: rtl/fan_power_ctrl.sv
// fan_power_ctrl: level stepping FSM with soft duty ramp, LED bar and motor PWM
module fan_power_ctrl
    import fan_pkg::*;
#(
    parameter int NUM_LEVELS = 3,
    parameter int DUTY_STEP  = DEF_DUTY_STEP,
    parameter int DUTY_MAX   = DEF_DUTY_MAX,
    parameter int PWM_DIV    = 1,
    parameter int RAMP_DIV   = 4,
    parameter int HARD_STOP  = 0
) (
    input  logic                                clk,
    input  logic                                reset_p,
    input  logic                                btn_up_pe,
    input  logic                                btn_off_pe,
    input  logic                                timer_end,
    input  logic                                stop_req,
    output logic                                motor_pwm,
    output logic [NUM_LEVELS-1:0]               led_power,
    output logic [$clog2(NUM_LEVELS+1)-1:0]     level,
    output logic [$clog2(DUTY_MAX+1)-1:0]       duty_cur,
    output logic                                motor_idle
);
    localparam int DUTY_W = $clog2(DUTY_MAX + 1);
    localparam int LVL_W  = $clog2(NUM_LEVELS + 1);
    localparam int RAMP_W = $clog2(RAMP_DIV + 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [LVL_W-1:0]  LVL_TOP   = LVL_W'(NUM_LEVELS);
    if (NUM_LEVELS < 1 || NUM_LEVELS > 15 || NUM_LEVELS * DUTY_STEP > DUTY_MAX) begin : g_bad_cfg
        $error("fan_power_ctrl: NUM_LEVELS must be 1..15 and NUM_LEVELS*DUTY_STEP must not exceed DUTY_MAX");
    end
    fan_state_t        state, st_nxt;
    logic [LVL_W-1:0]  lvl_nxt;
    logic [DUTY_W-1:0] target;
    logic [RAMP_W-1:0] ramp_cnt;
    logic              stop, go_up, kill, ramp_tick;
    assign stop       = timer_end | stop_req;
    assign go_up      = btn_up_pe & ~btn_off_pe & ~stop;
    assign ramp_tick  = ramp_cnt == RAMP_LAST;
    assign motor_idle = state == IDLE;
    // next state/level: stop beats off beats up; a hard stop also zeroes duty immediately
    always_comb begin
        st_nxt  = state;
        lvl_nxt = level;
        kill    = 1'b0;
        case (state)
            IDLE: begin
                if (go_up) begin
                    st_nxt  = RUN;
                    lvl_nxt = LVL_W'(1);
                end
            end
            RUN: begin
                if (stop || btn_off_pe) begin
                    lvl_nxt = '0;
                    kill    = HARD_STOP != 0;
                    st_nxt  = (HARD_STOP != 0) ? IDLE : STOPPING;
                end else if (btn_up_pe) begin
                    lvl_nxt = (level == LVL_TOP) ? '0 : level + 1'b1;
                    st_nxt  = (level == LVL_TOP) ? STOPPING : RUN;
                end
            end
            STOPPING: begin
                if (go_up) begin
                    st_nxt  = RUN;
                    lvl_nxt = LVL_W'(1);
                end else if (duty_cur == '0) begin
                    st_nxt = IDLE;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end
    // state, level, target and LED bar registers plus the one-count-per-tick duty ramp
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state     <= IDLE;
            level     <= '0;
            target    <= '0;
            led_power <= '0;
            ramp_cnt  <= '0;
            duty_cur  <= '0;
        end else begin
            state     <= st_nxt;
            level     <= lvl_nxt;
            target    <= DUTY_W'(int'(lvl_nxt) * DUTY_STEP);
            led_power <= NUM_LEVELS'(lvl_onehot(4'(lvl_nxt)));
            ramp_cnt  <= ramp_tick ? '0 : ramp_cnt + 1'b1;
            duty_cur  <= kill ? '0 :
                         (ramp_tick && duty_cur < target) ? duty_cur + 1'b1 :
                         (ramp_tick && duty_cur > target) ? duty_cur - 1'b1 : duty_cur;
        end
    end
    fan_pwm_gen #(
        .DUTY_MAX (DUTY_MAX),
        .PWM_DIV  (PWM_DIV)
    ) u_pwm (
        .clk     (clk),
        .reset_p (reset_p),
        .duty    (duty_cur),
        .pwm     (motor_pwm)
    );
endmodule

// File: tb/tb_fan_power_ctrl.sv
// tb_fan_power_ctrl: random stimulus on two configurations checked against a cycle-level behavioural model
module tb_fan_power_ctrl;
    localparam int P_NL [2] = '{3, 4};
    localparam int P_DS [2] = '{10, 5};
    localparam int P_DM [2] = '{100, 20};
    localparam int P_PD [2] = '{1, 2};
    localparam int P_RD [2] = '{4, 3};
    localparam int P_HS [2] = '{0, 1};
    localparam int S_IDLE = 0, S_RUN = 1, S_STOP = 2;
    localparam int CYCLES = 30000;

    typedef struct {
        int st;
        int lvl;
        int duty;
        int tgt;
        int pwm;
    } mstate_t;

    logic clk = 1'b0;
    logic reset_p, btn_up_pe, btn_off_pe, timer_end, stop_req;
    logic       pwm0, idle0, pwm1, idle1;
    logic [2:0] led0;
    logic [1:0] lvl0;
    logic [6:0] duty0;
    logic [3:0] led1;
    logic [2:0] lvl1;
    logic [4:0] duty1;
    mstate_t m [2];
    int k = 0;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fan_power_ctrl #(
        .NUM_LEVELS(P_NL[0]), .DUTY_STEP(P_DS[0]), .DUTY_MAX(P_DM[0]),
        .PWM_DIV(P_PD[0]), .RAMP_DIV(P_RD[0]), .HARD_STOP(P_HS[0])
    ) dut0 (
        .clk(clk), .reset_p(reset_p), .btn_up_pe(btn_up_pe), .btn_off_pe(btn_off_pe),
        .timer_end(timer_end), .stop_req(stop_req), .motor_pwm(pwm0), .led_power(led0),
        .level(lvl0), .duty_cur(duty0), .motor_idle(idle0)
    );

    fan_power_ctrl #(
        .NUM_LEVELS(P_NL[1]), .DUTY_STEP(P_DS[1]), .DUTY_MAX(P_DM[1]),
        .PWM_DIV(P_PD[1]), .RAMP_DIV(P_RD[1]), .HARD_STOP(P_HS[1])
    ) dut1 (
        .clk(clk), .reset_p(reset_p), .btn_up_pe(btn_up_pe), .btn_off_pe(btn_off_pe),
        .timer_end(timer_end), .stop_req(stop_req), .motor_pwm(pwm1), .led_power(led1),
        .level(lvl1), .duty_cur(duty1), .motor_idle(idle1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s at k=%0d: got %0d, expected %0d", tag, k, got, exp);
        end
    endtask

    // one clock edge of behaviour for configuration i, kk = edges since reset
    function automatic mstate_t step(input mstate_t s, input int i, input int kk,
                                     input bit stp, input bit off, input bit up);
        mstate_t n = s;
        n.pwm = (((kk / P_PD[i]) % P_DM[i]) < s.duty) ? 1 : 0;
        if ((kk % P_RD[i]) == P_RD[i] - 1 && s.duty != s.tgt)
            n.duty = s.duty + ((s.duty < s.tgt) ? 1 : -1);
        if (s.st == S_IDLE) begin
            if (!stp && !off && up) begin
                n.st = S_RUN;
                n.lvl = 1;
            end
        end else if (s.st == S_RUN) begin
            if (stp || off) begin
                n.lvl = 0;
                n.st = P_HS[i] ? S_IDLE : S_STOP;
                if (P_HS[i] != 0) n.duty = 0;
            end else if (up) begin
                n.lvl = (s.lvl == P_NL[i]) ? 0 : s.lvl + 1;
                n.st = (s.lvl == P_NL[i]) ? S_STOP : S_RUN;
            end
        end else begin
            if (!stp && !off && up) begin
                n.st = S_RUN;
                n.lvl = 1;
            end else if (s.duty == 0) begin
                n.st = S_IDLE;
            end
        end
        n.tgt = n.lvl * P_DS[i];
        return n;
    endfunction

    function automatic int onehot(input int lvl);
        return (lvl == 0) ? 0 : (1 << (lvl - 1));
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            m[i] <= reset_p ? '{S_IDLE, 0, 0, 0, 0}
                            : step(m[i], i, k, timer_end | stop_req, btn_off_pe, btn_up_pe);
        k <= reset_p ? 0 : k + 1;
    end

    task automatic check_all();
        check("level0", 32'(lvl0), m[0].lvl);
        check("led0", 32'(led0), onehot(m[0].lvl));
        check("duty0", 32'(duty0), m[0].duty);
        check("idle0", 32'(idle0), (m[0].st == S_IDLE) ? 1 : 0);
        check("pwm0", 32'(pwm0), m[0].pwm);
        check("level1", 32'(lvl1), m[1].lvl);
        check("led1", 32'(led1), onehot(m[1].lvl));
        check("duty1", 32'(duty1), m[1].duty);
        check("idle1", 32'(idle1), (m[1].st == S_IDLE) ? 1 : 0);
        check("pwm1", 32'(pwm1), m[1].pwm);
    endtask

    initial begin
        reset_p = 1'b1;
        btn_up_pe = 1'b0;
        btn_off_pe = 1'b0;
        timer_end = 1'b0;
        stop_req = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        reset_p = 1'b0;
        btn_up_pe = 1'b1;
        for (int n = 0; n < CYCLES; n++) begin
            @(negedge clk);
            check_all();
            reset_p = $urandom_range(0, 3999) == 0;
            btn_up_pe = $urandom_range(0, 59) == 0;
            btn_off_pe = $urandom_range(0, 399) == 0;
            if ($urandom_range(0, 399) == 0) begin
                btn_up_pe = 1'b1;
                btn_off_pe = 1'b1;
            end
            timer_end = $urandom_range(0, 499) == 0;
            stop_req = stop_req ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 999) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
